uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin scheduler that shares one UART transmitter among `NUM_REQ` byte sources. It sits between the requesters and the transmitter and sequences whole frames: grant, start, wait for completion, then an inter-frame gap. The gap is timed in baud-rate generator ticks (`i_brg_tck`) so that frame spacing tracks the configured baud rate.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; must be 2..16.
- `DATA_BITS`, 8: frame payload width.
- `GAP_TICKS`, 16: `i_brg_tck` pulses of idle line enforced after each frame; 0 disables the gap.
- `TIMEOUT_TICKS`, 4096: watchdog limit in `i_brg_tck` pulses. Used only when the watchdog is compiled in.

Ports:
- `i_clk`  in  1  system clock. Single clock domain.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  NUM_REQ  level request per source. Held until granted.
- `i_data`  in  NUM_REQ*DATA_BITS  flattened payloads. Source k occupies `[k*DATA_BITS +: DATA_BITS]`.
- `o_gnt`  out  NUM_REQ  one-hot, 1-cycle pulse. Payload of that source is consumed.
- `o_tx_start`  out  1  1-cycle pulse to the transmitter.
- `o_tx_data`  out  DATA_BITS  registered payload. Stable from `o_tx_start` until the next grant.
- `i_tx_done`  in  1  1-cycle pulse from the transmitter at end of stop bit.
- `i_brg_tck`  in  1  baud-rate generator tick, 1-cycle pulse.
- `o_busy`  out  1  high in every state except IDLE.
- `o_owner`  out  max(1,$clog2(NUM_REQ))  index of the last granted source.
- `o_timeout`  out  1  1-cycle pulse when the watchdog fires. Only present with `UART_ARB_WATCHDOG_EN`.

## Operation
- FSM states: IDLE, GRANT, WAIT_DONE, GAP.
- IDLE: if any `i_req` is high, select the winner and go to GRANT. Otherwise stay in IDLE.
- Winner selection: search round-robin starting at `ptr`, wrapping from NUM_REQ-1 to 0. Selection is combinational on `i_req` and `ptr`, and is registered on entry to GRANT.
- GRANT (exactly 1 cycle):
  - `o_gnt[w]`=1 and `o_tx_start`=1.
  - `o_tx_data` and `o_owner` are loaded.
  - `ptr` becomes (w+1) mod NUM_REQ.
  - Next state is WAIT_DONE.
- WAIT_DONE: on `i_tx_done`, go to GAP, or straight to IDLE when `GAP_TICKS`=0.
- `i_tx_done` is ignored in every state other than WAIT_DONE.
- GAP:
  - The counter clears on entry and increments on each `i_brg_tck`.
  - When it reaches `GAP_TICKS` (the tick that makes count==GAP_TICKS), go to IDLE.
  - The counter is `$clog2(GAP_TICKS+1)` bits wide and never wraps.
- Request dropped before grant: no grant is issued; arbitration is re-evaluated next cycle.
- Requests from the current owner during WAIT_DONE or GAP are held off. Arbitration happens only in IDLE.
- Reset (asynchronous, at any point mid-frame):
  - State returns to IDLE, `ptr`=0.
  - All outputs are 0: `o_gnt`, `o_tx_start`, `o_tx_data`, `o_owner`, `o_busy`, `o_timeout`.
  - Counters clear.

## Timing
- Request to grant: `i_req` sampled high in IDLE at edge N gives `o_gnt`/`o_tx_start` high during cycle N+1. Latency is 1 cycle.
- `i_tx_done` at edge M gives GAP (or IDLE) from M+1. `o_busy` drops the cycle after the final gap tick.
- Minimum frame-to-frame spacing at the transmitter: done, then GAP_TICKS ticks, then 1 IDLE cycle, then GRANT.
- `i_brg_tck` coinciding with the GAP entry cycle is not counted. Counting starts the cycle after entry.
- `i_tx_done` coinciding with `o_tx_start` (GRANT cycle) is ignored.

## Configuration
- `UART_ARB_WATCHDOG_EN` defined:
  - In WAIT_DONE, count `i_brg_tck` pulses.
  - When the count reaches `TIMEOUT_TICKS` without `i_tx_done`, pulse `o_timeout` for 1 cycle and go to GAP as if done.
  - If `i_tx_done` and the limit tick arrive in the same cycle, done wins and there is no timeout.
  - The counter clears on each entry to WAIT_DONE.
- `UART_ARB_WATCHDOG_EN` undefined:
  - No counter and no `o_timeout` port.
  - WAIT_DONE waits indefinitely.

## Structure
- Shared package `uart_pkg`: FSM state encoding (2-bit: IDLE=0, GRANT=1, WAIT_DONE=2, GAP=3) and the default DATA_BITS constant.
- One sub-module, `rr_arbiter`:
  - Parameterised NUM_REQ.
  - Inputs: `req` and `ptr`. Outputs: one-hot `win` and index `win_idx`.
  - Purely combinational.
  - The pointer register lives in the parent.

## Test plan
- Single request, GAP_TICKS=16: `i_req`=4'b0100, data 8'hA5. Expect `o_gnt`=4'b0100 and `o_tx_start` 1 cycle later, `o_tx_data`=8'hA5, `o_owner`=2. After `i_tx_done`, `o_busy` stays high for exactly 16 `i_brg_tck`.
- Fairness: all four `i_req` held high continuously. Expect grant order 0,1,2,3,0 with one grant per frame.
- Wrap and skip: `ptr`=3, `i_req`=4'b0011. Expect grant to source 0, then source 1.
- Reset mid-frame: assert `i_reset_n`=0 in WAIT_DONE. Expect all outputs 0 immediately. After release with `i_req`=4'b1000, grant to source 3.
- Spurious done: `i_tx_done` pulsed in IDLE and in the GRANT cycle. Expect no state change, and WAIT_DONE still waits for a later done.
- Watchdog (macro defined, TIMEOUT_TICKS=8): no `i_tx_done`. Expect `o_timeout` on the 8th tick, then GAP. With done on that same tick, expect no `o_timeout`.

Source files
------------

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit arbiter:
//   - arb_state_t       : 2-bit FSM encoding (IDLE=0, GRANT=1, WAIT_DONE=2, GAP=3)
//   - DEFAULT_DATA_BITS : default frame payload width
//   - idx_width()       : width of a requester index, never below 1 bit
//   - wrap_add()        : (base + off) mod n, for base < n and off < n
// ----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_GRANT     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } arb_state_t;

    localparam int DEFAULT_DATA_BITS = 8;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int wrap_add(input int base, input int off, input int n);
        return ((base + off) >= n) ? (base + off - n) : (base + off);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin winner selection. The search starts at
// ptr and wraps from NUM_REQ-1 to 0; the first asserted request wins.
// The pointer register is owned by the parent.
// Ports:
//   req     in  NUM_REQ  request vector
//   ptr     in  IW       index where the search starts
//   win     out NUM_REQ  one-hot winner (all zero when req is zero)
//   win_idx out IW       index of the winner (0 when req is zero)
// ----------------------------------------------------------------------------
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = idx_width(NUM_REQ)
)
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [IW-1:0]      win_idx
);

    logic found_s;

    // Walk the requesters in priority order from ptr; the first hit is kept.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            win[wrap_add(int'(ptr), i, NUM_REQ)] =
                win[wrap_add(int'(ptr), i, NUM_REQ)] |
                (!found_s && req[wrap_add(int'(ptr), i, NUM_REQ)]);
            win_idx = (!found_s && req[wrap_add(int'(ptr), i, NUM_REQ)]) ?
                      IW'(wrap_add(int'(ptr), i, NUM_REQ)) : win_idx;
            found_s = found_s | req[wrap_add(int'(ptr), i, NUM_REQ)];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin scheduler sharing one UART transmitter among NUM_REQ sources.
// Sequence per frame: IDLE -> GRANT (1 cycle) -> WAIT_DONE -> GAP -> IDLE.
// The inter-frame gap is counted in baud-rate generator ticks.
// Optional feature macro: UART_ARB_WATCHDOG_EN adds a WAIT_DONE watchdog
// (TIMEOUT_TICKS brg ticks) and the o_timeout port.
// Ports:
//   i_clk, i_reset_n   clock, asynchronous active-low reset
//   i_req   [NUM_REQ]  level requests, held until granted
//   i_data             flattened payloads, source k at [k*DATA_BITS +: DATA_BITS]
//   o_gnt   [NUM_REQ]  one-hot 1-cycle grant pulse
//   o_tx_start         1-cycle start pulse to the transmitter
//   o_tx_data          registered payload of the granted source
//   i_tx_done          end-of-frame pulse from the transmitter
//   i_brg_tck          baud-rate tick
//   o_busy             high in every state except IDLE
//   o_owner            index of the last granted source
//   o_timeout          watchdog pulse (only with UART_ARB_WATCHDOG_EN)
// ----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int DATA_BITS     = DEFAULT_DATA_BITS,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 4096
)
(
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   i_data,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic                           o_tx_start,
    output logic [DATA_BITS-1:0]           o_tx_data,
    input  logic                           i_tx_done,
    input  logic                           i_brg_tck,
    output logic                           o_busy,
    output logic [idx_width(NUM_REQ)-1:0]  o_owner
`ifdef UART_ARB_WATCHDOG_EN
    ,
    output logic                           o_timeout
`endif
);

    localparam int IW       = idx_width(NUM_REQ);
    localparam int GW       = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int GAP_LAST = (GAP_TICKS > 0) ? (GAP_TICKS - 1) : 0;

    arb_state_t          state_r;
    logic [IW-1:0]       ptr_r;
    logic [GW-1:0]       gap_cnt_r;
    logic [NUM_REQ-1:0]  win_s;
    logic [IW-1:0]       win_idx_s;
    logic                wd_fire_s;
    logic                frame_end_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req     (i_req),
        .ptr     (ptr_r),
        .win     (win_s),
        .win_idx (win_idx_s)
    );

`ifdef UART_ARB_WATCHDOG_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);

    logic [TW-1:0] wd_cnt_r;

    // A done in the same cycle as the limit tick takes precedence.
    assign wd_fire_s = (state_r == ST_WAIT_DONE) && !i_tx_done && i_brg_tck &&
                       (wd_cnt_r == TW'(TIMEOUT_TICKS - 1));

    // Watchdog tick counter (cleared while in GRANT, i.e. on WAIT_DONE entry) and timeout pulse.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wd_cnt_r  <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= wd_fire_s;
            if (state_r == ST_GRANT) begin
                wd_cnt_r <= '0;
            end else if ((state_r == ST_WAIT_DONE) && i_brg_tck && !wd_fire_s) begin
                wd_cnt_r <= wd_cnt_r + TW'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
        end
    end
`else
    assign wd_fire_s = 1'b0;
`endif

    assign frame_end_s = (state_r == ST_WAIT_DONE) && (i_tx_done || wd_fire_s);

    // Main sequencing FSM with registered grant/start/data/owner/busy outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r    <= ST_IDLE;
            ptr_r      <= '0;
            gap_cnt_r  <= '0;
            o_gnt      <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_owner    <= '0;
            o_busy     <= 1'b0;
        end else begin
            o_gnt      <= '0;
            o_tx_start <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|i_req) begin
                        // Grant outputs are loaded on the edge entering GRANT
                        // so they are visible during the GRANT cycle itself.
                        state_r    <= ST_GRANT;
                        o_gnt      <= win_s;
                        o_tx_start <= 1'b1;
                        o_tx_data  <= i_data[int'(win_idx_s)*DATA_BITS +: DATA_BITS];
                        o_owner    <= win_idx_s;
                        ptr_r      <= (win_idx_s == IW'(NUM_REQ - 1)) ? '0 : (win_idx_s + IW'(1));
                        o_busy     <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                ST_GRANT: begin
                    state_r <= ST_WAIT_DONE;
                    o_busy  <= 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (frame_end_s) begin
                        if (GAP_TICKS == 0) begin
                            state_r <= ST_IDLE;
                            o_busy  <= 1'b0;
                        end else begin
                            state_r   <= ST_GAP;
                            gap_cnt_r <= '0;
                            o_busy    <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_WAIT_DONE;
                        o_busy  <= 1'b1;
                    end
                end
                ST_GAP: begin
                    // Leave on the tick that makes the count equal GAP_TICKS;
                    // the counter therefore never wraps.
                    if (i_brg_tck && (gap_cnt_r == GW'(GAP_LAST))) begin
                        state_r <= ST_IDLE;
                        o_busy  <= 1'b0;
                    end else if (i_brg_tck) begin
                        gap_cnt_r <= gap_cnt_r + GW'(1);
                        o_busy    <= 1'b1;
                    end else begin
                        o_busy <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ----------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed self-checking bench for uart_tx_arbiter (NUM_REQ=4, DATA_BITS=8,
// GAP_TICKS=16, TIMEOUT_TICKS=8). Inputs are driven and outputs sampled on
// the falling clock edge. Watchdog scenario runs only with
// UART_ARB_WATCHDOG_EN defined.
// ----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DB   = 8;
    localparam int GAP  = 16;
    localparam int TMO  = 8;

    logic            clk;
    logic            rst_n;
    logic [NREQ-1:0] req;
    logic [NREQ*DB-1:0] data;
    logic [NREQ-1:0] gnt;
    logic            tx_start;
    logic [DB-1:0]   tx_data;
    logic            tx_done;
    logic            brg_tck;
    logic            busy;
    logic [1:0]      owner;
`ifdef UART_ARB_WATCHDOG_EN
    logic            timeout;
`endif

    int checks   = 0;
    int failures = 0;

    uart_tx_arbiter #(
        .NUM_REQ       (NREQ),
        .DATA_BITS     (DB),
        .GAP_TICKS     (GAP),
        .TIMEOUT_TICKS (TMO)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_req      (req),
        .i_data     (data),
        .o_gnt      (gnt),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .i_tx_done  (tx_done),
        .i_brg_tck  (brg_tck),
        .o_busy     (busy),
        .o_owner    (owner)
`ifdef UART_ARB_WATCHDOG_EN
        ,
        .o_timeout  (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    task automatic reset_dut();
        rst_n   = 1'b0;
        req     = '0;
        tx_done = 1'b0;
        brg_tck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_tick();
        brg_tck = 1'b1;
        @(negedge clk);
        brg_tck = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    // Move into WAIT_DONE if still in GRANT, then done and a full gap.
    task automatic finish_frame();
        @(negedge clk);
        pulse_done();
        repeat (GAP) pulse_tick();
    endtask

    task automatic wait_grant(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (gnt != '0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; tx_done = 1'b0; brg_tck = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_start got=%b exp=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", tx_data); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        req = 4'b0100;
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (tx_start !== 1'b1) begin failures++; $display("FAIL single_start got=%b exp=1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", tx_data); end
        checks++; if (owner !== 2'd2) begin failures++; $display("FAIL single_owner got=%0d exp=2", owner); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_grant got=%b exp=1", busy); end
        req = 4'b0000;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_pulse got=%b exp=0000", gnt); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL single_start_pulse got=%b exp=0", tx_start); end
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_wait got=%b exp=1", busy); end
        // Tick coinciding with done is not counted toward the gap.
        tx_done = 1'b1; brg_tck = 1'b1;
        @(negedge clk);
        tx_done = 1'b0; brg_tck = 1'b0;
        for (int k = 1; k <= GAP; k++) begin
            pulse_tick();
            checks++;
            if (busy !== ((k < GAP) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL single_gap_busy tick=%0d got=%b exp=%b", k, busy, (k < GAP) ? 1'b1 : 1'b0);
            end
        end
        checks++; if (tx_data !== 8'hA5) begin failures++; $display("FAIL single_data_hold got=%h exp=a5", tx_data); end
    endtask

    task automatic test_fairness();
        bit seen;
        logic [3:0] exp_gnt;
        logic [7:0] exp_byte;
        reset_dut();
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            exp_gnt  = 4'b0001 << (f % 4);
            exp_byte = data[(f % 4)*8 +: 8];
            wait_grant(seen);
            checks++; if (!seen) begin failures++; $display("FAIL fair_seen frame=%0d got=none exp=grant", f); end
            checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL fair_gnt frame=%0d got=%b exp=%b", f, gnt, exp_gnt); end
            checks++; if (tx_data !== exp_byte) begin failures++; $display("FAIL fair_data frame=%0d got=%h exp=%h", f, tx_data, exp_byte); end
            @(negedge clk);
            checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL fair_one_grant frame=%0d got=%b exp=0000", f, gnt); end
            if (f == 4) req = 4'b0000;
            finish_frame();
        end
    endtask

    task automatic test_wrap_skip();
        bit seen;
        reset_dut();
        req = 4'b0100;
        wait_grant(seen);
        req = 4'b0000;
        finish_frame();
        req = 4'b0011;
        wait_grant(seen);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt0 got=%b exp=0001", gnt); end
        checks++; if (owner !== 2'd0) begin failures++; $display("FAIL wrap_owner0 got=%0d exp=0", owner); end
        req = 4'b0010;
        finish_frame();
        wait_grant(seen);
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wrap_gnt1 got=%b exp=0010", gnt); end
        checks++; if (owner !== 2'd1) begin failures++; $display("FAIL wrap_owner1 got=%0d exp=1", owner); end
        req = 4'b0000;
        finish_frame();
    endtask

    task automatic test_reset_mid();
        bit seen;
        req = 4'b0001;
        wait_grant(seen);
        req = 4'b0000;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rmid_data got=%h exp=00", tx_data); end
        checks++; if (gnt !== 4'b0000 || tx_start !== 1'b0 || owner !== 2'd0) begin
            failures++; $display("FAIL rmid_outputs got=%b/%b/%0d exp=0000/0/0", gnt, tx_start, owner);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1000;
        wait_grant(seen);
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL rmid_gnt got=%b exp=1000", gnt); end
        checks++; if (owner !== 2'd3) begin failures++; $display("FAIL rmid_owner got=%0d exp=3", owner); end
        req = 4'b0000;
        finish_frame();
    endtask

    task automatic test_spurious_done();
        pulse_done();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL spur_idle_gnt got=%b exp=0000", gnt); end
        req = 4'b0001;
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL spur_gnt got=%b exp=0001", gnt); end
        // Done during the GRANT cycle must be ignored.
        req = 4'b0000;
        pulse_done();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spur_wait_busy got=%b exp=1", busy); end
        repeat (GAP) pulse_tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL spur_still_waiting got=%b exp=1", busy); end
        finish_frame();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL spur_end_busy got=%b exp=0", busy); end
    endtask

`ifdef UART_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        bit seen;
        req = 4'b0010;
        wait_grant(seen);
        req = 4'b0000;
        @(negedge clk);
        repeat (TMO - 1) pulse_tick();
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_early got=%b exp=0", timeout); end
        pulse_tick();
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL wd_fire got=%b exp=1", timeout); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_pulse got=%b exp=0", timeout); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_gap_busy got=%b exp=1", busy); end
        repeat (GAP) pulse_tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_gap_end got=%b exp=0", busy); end
        req = 4'b0100;
        wait_grant(seen);
        req = 4'b0000;
        @(negedge clk);
        repeat (TMO - 1) pulse_tick();
        tx_done = 1'b1; brg_tck = 1'b1;
        @(negedge clk);
        tx_done = 1'b0; brg_tck = 1'b0;
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL wd_done_wins got=%b exp=0", timeout); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL wd_done_gap got=%b exp=1", busy); end
        repeat (GAP) pulse_tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL wd_done_end got=%b exp=0", busy); end
    endtask
`endif

    initial begin
        data    = {8'h13, 8'hA5, 8'h11, 8'h10};
        req     = '0;
        tx_done = 1'b0;
        brg_tck = 1'b0;
        rst_n   = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_wrap_skip();
        test_reset_mid();
        test_spurious_done();
`ifdef UART_ARB_WATCHDOG_EN
        test_watchdog();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
